// File: rtl/irrigation_zone_scheduler.sv
// Round-robin irrigation zone scheduler with tank-level fault detection.
// Define IRRIGATION_FAULT_LATCH_EN to hold FAULT until an operator pulse.
module irrigation_zone_scheduler #(
    parameter int ZONES     = 4,
    parameter int RUN_TICKS = 10,
    parameter int TW        = 8,
    parameter int TICK_DIV  = 1000,
    localparam int ZW       = (ZONES > 1) ? $clog2(ZONES) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             low_water_level,
    input  logic             mid_water_level,
    input  logic             high_water_level,
    input  logic [ZONES-1:0] earth_dry,
    input  logic             air_humidity,
    input  logic             low_temperature,
    input  logic             pulse,
    output logic [ZONES-1:0] zone_valve,
    output logic [ZW-1:0]    active_zone,
    output logic             splinker_bomb,
    output logic             dripper_valvule,
    output logic             water_supply_valvule,
    output logic             alarm,
    output logic [TW-1:0]    remaining
);

    localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int ZW1 = ZW + 1;

    typedef enum logic [1:0] {IDLE, IRRIGATE, PAUSE, FAULT} state_t;

    state_t          state, nxt_state;
    logic [PW-1:0]   pre_cnt;
    logic            tick;
    logic            conflict;
    logic [ZW-1:0]   last_zone, nxt_last, nxt_act, pick;
    logic [TW-1:0]   nxt_rem;
    logic            mode_spl, nxt_mode;
    logic            found;
    logic [ZW1-1:0]  cand;
    logic            irr;

    assign conflict = (high_water_level & ~mid_water_level)
                    | (mid_water_level & ~low_water_level);
    assign tick = (pre_cnt == PW'(TICK_DIV - 1));

`ifndef IRRIGATION_FAULT_LATCH_EN
    logic unused_pulse;
    assign unused_pulse = pulse;
`endif

    // First requester strictly after last_zone, wrapping; last_zone itself is checked last.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 1; i <= ZONES; i++) begin
            cand = {1'b0, last_zone} + ZW1'(i);
            if (cand >= ZW1'(ZONES))
                cand = cand - ZW1'(ZONES);
            if (!found && earth_dry[cand[ZW-1:0]]) begin
                found = 1'b1;
                pick  = cand[ZW-1:0];
            end
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_rem   = remaining;
        nxt_act   = active_zone;
        nxt_last  = last_zone;
        nxt_mode  = mode_spl;
        if (conflict) begin
            nxt_state = FAULT;
            nxt_rem   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found && low_water_level) begin
                        nxt_state = IRRIGATE;
                        nxt_act   = pick;
                        nxt_rem   = TW'(RUN_TICKS);
                        nxt_mode  = ~air_humidity & ~low_temperature
                                  & mid_water_level;
                    end
                end
                IRRIGATE: begin
                    if (!low_water_level) begin
                        nxt_state = PAUSE;
                    end else if (!earth_dry[active_zone]
                                 || (tick && remaining <= TW'(1))) begin
                        nxt_state = IDLE;
                        nxt_rem   = '0;
                        nxt_last  = active_zone;
                    end else if (tick) begin
                        nxt_rem = remaining - TW'(1);
                    end
                end
                PAUSE: begin
                    if (low_water_level)
                        nxt_state = IRRIGATE;
                end
                FAULT: begin
`ifdef IRRIGATION_FAULT_LATCH_EN
                    if (pulse)
                        nxt_state = IDLE;
`else
                    nxt_state = IDLE;
`endif
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    assign irr = (nxt_state == IRRIGATE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            pre_cnt              <= '0;
            remaining            <= '0;
            last_zone            <= ZW'(ZONES - 1);
            active_zone          <= '0;
            mode_spl             <= 1'b0;
            zone_valve           <= '0;
            splinker_bomb        <= 1'b0;
            dripper_valvule      <= 1'b0;
            water_supply_valvule <= 1'b0;
            alarm                <= 1'b0;
        end else begin
            pre_cnt              <= tick ? '0 : pre_cnt + PW'(1);
            state                <= nxt_state;
            remaining            <= nxt_rem;
            last_zone            <= nxt_last;
            active_zone          <= nxt_act;
            mode_spl             <= nxt_mode;
            zone_valve           <= irr ? (ZONES'(1) << nxt_act) : '0;
            splinker_bomb        <= irr & nxt_mode;
            dripper_valvule      <= irr & ~nxt_mode;
            water_supply_valvule <= ~high_water_level & ~conflict
                                  & (nxt_state != FAULT);
            alarm                <= (nxt_state == FAULT) | ~mid_water_level;
        end
    end

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Directed bench for irrigation_zone_scheduler (ZONES=4, RUN_TICKS=3, TICK_DIV=2).
module tb_irrigation_zone_scheduler;

    localparam int ZONES = 4;
    localparam int TW    = 8;

    logic             clock;
    logic             reset;
    logic             low_water_level, mid_water_level, high_water_level;
    logic [ZONES-1:0] earth_dry;
    logic             air_humidity, low_temperature, pulse;
    logic [ZONES-1:0] zone_valve;
    logic [1:0]       active_zone;
    logic             splinker_bomb, dripper_valvule;
    logic             water_supply_valvule, alarm;
    logic [TW-1:0]    remaining;

    int n_checks;
    int n_fail;

    irrigation_zone_scheduler #(
        .ZONES(ZONES), .RUN_TICKS(3), .TW(TW), .TICK_DIV(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .low_water_level(low_water_level),
        .mid_water_level(mid_water_level),
        .high_water_level(high_water_level),
        .earth_dry(earth_dry),
        .air_humidity(air_humidity),
        .low_temperature(low_temperature),
        .pulse(pulse),
        .zone_valve(zone_valve),
        .active_zone(active_zone),
        .splinker_bomb(splinker_bomb),
        .dripper_valvule(dripper_valvule),
        .water_supply_valvule(water_supply_valvule),
        .alarm(alarm),
        .remaining(remaining)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic set_levels(input logic h, input logic m, input logic l);
        high_water_level = h;
        mid_water_level  = m;
        low_water_level  = l;
    endtask

    task automatic test_reset();
        @(negedge clock);
        n_checks++;
        if (zone_valve !== 4'b0) begin
            n_fail++; $display("FAIL reset_valve got %b want 0000", zone_valve);
        end
        n_checks++;
        if (remaining !== 8'd0 || active_zone !== 2'd0) begin
            n_fail++; $display("FAIL reset_rem got %0d/%0d want 0/0", remaining, active_zone);
        end
        n_checks++;
        if ({splinker_bomb, dripper_valvule, water_supply_valvule, alarm} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_outs got %b want 0000",
                     {splinker_bomb, dripper_valvule, water_supply_valvule, alarm});
        end
        set_levels(1'b1, 1'b1, 1'b1);
        air_humidity = 1'b1;
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        n_checks++;
        if (alarm !== 1'b0 || water_supply_valvule !== 1'b0) begin
            n_fail++; $display("FAIL idle_full got alarm=%b water=%b want 0/0",
                               alarm, water_supply_valvule);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] seq [3];
        int         dur [3];
        int         starts, ends, cur;
        logic [3:0] prev;
        starts = 0; ends = 0; cur = 0;
        prev = zone_valve;
        earth_dry = 4'b0101;
        for (int c = 0; c < 80 && ends < 3; c++) begin
            @(negedge clock);
            if (zone_valve != 4'b0 && prev == 4'b0) begin
                if (starts < 3) seq[starts] = zone_valve;
                starts++;
                cur = 1;
                n_checks++;
                if (remaining !== 8'd3 || dripper_valvule !== 1'b1) begin
                    n_fail++; $display("FAIL grant_load got rem=%0d drip=%b want 3/1",
                                       remaining, dripper_valvule);
                end
            end else if (zone_valve != 4'b0) begin
                cur++;
            end else if (prev != 4'b0) begin
                if (ends < 3) dur[ends] = cur;
                ends++;
            end
            prev = zone_valve;
        end
        earth_dry = 4'b0;
        n_checks++;
        if (ends < 3) begin
            n_fail++; $display("FAIL rr_timeout got %0d grants want 3", ends);
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (seq[k] !== ((k == 1) ? 4'b0100 : 4'b0001)) begin
                    n_fail++; $display("FAIL rr_order[%0d] got %b want %b", k, seq[k],
                                       (k == 1) ? 4'b0100 : 4'b0001);
                end
                n_checks++;
                if (dur[k] < 5 || dur[k] > 6) begin
                    n_fail++; $display("FAIL rr_dur[%0d] got %0d want 5..6", k, dur[k]);
                end
            end
        end
        repeat (3) @(negedge clock);
        n_checks++;
        if (zone_valve !== 4'b0) begin
            n_fail++; $display("FAIL rr_stop got %b want 0000", zone_valve);
        end
    endtask

    task automatic test_pause();
        bit ok;
        int n;
        ok = 1'b0;
        earth_dry = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (remaining == 8'd2 && zone_valve == 4'b0010) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL pause_grant got rem=%0d want 2", remaining);
        end
        set_levels(1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge clock);
        n_checks++;
        if (zone_valve !== 4'b0 || dripper_valvule !== 1'b0) begin
            n_fail++; $display("FAIL pause_valves got %b/%b want 0000/0",
                               zone_valve, dripper_valvule);
        end
        n_checks++;
        if (remaining !== 8'd2) begin
            n_fail++; $display("FAIL pause_hold got %0d want 2", remaining);
        end
        n_checks++;
        if (water_supply_valvule !== 1'b1 || alarm !== 1'b1) begin
            n_fail++; $display("FAIL pause_tank got water=%b alarm=%b want 1/1",
                               water_supply_valvule, alarm);
        end
        set_levels(1'b1, 1'b1, 1'b1);
        @(negedge clock);
        n_checks++;
        if (zone_valve !== 4'b0010 || remaining !== 8'd2) begin
            n_fail++; $display("FAIL resume got %b rem=%0d want 0010 rem=2",
                               zone_valve, remaining);
        end
        n = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            n++;
            if (zone_valve == 4'b0) break;
        end
        earth_dry = 4'b0;
        n_checks++;
        if (n < 4 || n > 5 || remaining !== 8'd0) begin
            n_fail++; $display("FAIL resume_expire got %0d cycles rem=%0d want 4..5 rem=0",
                               n, remaining);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_fault();
        bit ok;
        ok = 1'b0;
        earth_dry = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (zone_valve == 4'b0001) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL fault_grant got %b want 0001", zone_valve);
        end
        set_levels(1'b1, 1'b0, 1'b1);
        @(negedge clock);
        earth_dry = 4'b0;
        n_checks++;
        if (zone_valve !== 4'b0 || dripper_valvule !== 1'b0 || splinker_bomb !== 1'b0) begin
            n_fail++; $display("FAIL fault_valves got %b want 0000", zone_valve);
        end
        n_checks++;
        if (alarm !== 1'b1 || water_supply_valvule !== 1'b0) begin
            n_fail++; $display("FAIL fault_alarm got alarm=%b water=%b want 1/0",
                               alarm, water_supply_valvule);
        end
        repeat (3) @(negedge clock);
        n_checks++;
        if (alarm !== 1'b1) begin
            n_fail++; $display("FAIL fault_hold got %b want 1", alarm);
        end
        set_levels(1'b1, 1'b1, 1'b1);
`ifdef IRRIGATION_FAULT_LATCH_EN
        repeat (3) @(negedge clock);
        n_checks++;
        if (alarm !== 1'b1) begin
            n_fail++; $display("FAIL fault_latch got %b want 1", alarm);
        end
        pulse = 1'b1;
        @(negedge clock);
        pulse = 1'b0;
`else
        @(negedge clock);
`endif
        n_checks++;
        if (alarm !== 1'b0 || zone_valve !== 4'b0) begin
            n_fail++; $display("FAIL fault_exit got alarm=%b valve=%b want 0/0000",
                               alarm, zone_valve);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_mode();
        bit ok;
        ok = 1'b0;
        air_humidity    = 1'b0;
        low_temperature = 1'b0;
        earth_dry       = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (zone_valve == 4'b1000) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok || splinker_bomb !== 1'b1 || dripper_valvule !== 1'b0) begin
            n_fail++; $display("FAIL mode_spl got spl=%b drip=%b want 1/0",
                               splinker_bomb, dripper_valvule);
        end
        air_humidity = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if (splinker_bomb !== 1'b1 || dripper_valvule !== 1'b0) begin
            n_fail++; $display("FAIL mode_latch got spl=%b drip=%b want 1/0",
                               splinker_bomb, dripper_valvule);
        end
        earth_dry = 4'b0;
        repeat (2) @(negedge clock);
        n_checks++;
        if (splinker_bomb !== 1'b0 || zone_valve !== 4'b0) begin
            n_fail++; $display("FAIL mode_off got spl=%b valve=%b want 0/0000",
                               splinker_bomb, zone_valve);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        ok = 1'b0;
        earth_dry = 4'b0010;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (zone_valve == 4'b0010 && remaining == 8'd1) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL b2b_setup got rem=%0d want 1", remaining);
        end
        @(negedge clock);
        earth_dry = 4'b0;
        @(negedge clock);
        n_checks++;
        if (zone_valve !== 4'b0 || remaining !== 8'd0) begin
            n_fail++; $display("FAIL b2b_idle got %b rem=%0d want 0000 rem=0",
                               zone_valve, remaining);
        end
        earth_dry = 4'b0110;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (zone_valve != 4'b0) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok || zone_valve !== 4'b0100 || active_zone !== 2'd2) begin
            n_fail++; $display("FAIL b2b_next got %b zone=%0d want 0100 zone=2",
                               zone_valve, active_zone);
        end
        earth_dry = 4'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset_mid();
        bit ok;
        ok = 1'b0;
        earth_dry = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (zone_valve == 4'b0001) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL rst_mid_grant got %b want 0001", zone_valve);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (zone_valve !== 4'b0 || remaining !== 8'd0 || dripper_valvule !== 1'b0) begin
            n_fail++; $display("FAIL rst_async got %b rem=%0d want 0000 rem=0",
                               zone_valve, remaining);
        end
        earth_dry = 4'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        set_levels(1'b0, 1'b0, 1'b0);
        earth_dry       = 4'b0;
        air_humidity    = 1'b0;
        low_temperature = 1'b0;
        pulse           = 1'b0;
        test_reset();
        test_round_robin();
        test_pause();
        test_fault();
        test_mode();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irrigation_zone_scheduler.md
IRRIGATION_ZONE_SCHEDULER -- requirements
Module: irrigation_zone_scheduler

Interface
REQ-001 Parameter ZONES, 4, number of irrigation zones (1..8); ZW = max(1, clog2(ZONES)).
REQ-002 Parameter RUN_TICKS, 10, ticks of irrigation per zone grant (1..2^TW-1).
REQ-003 Parameter TW, 8, width of the run timer.
REQ-004 Parameter TICK_DIV, 1000, clock cycles per tick (>=1).
REQ-005 clock  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 low_water_level / mid_water_level / high_water_level  in  1 each  tank level probes, 1 = water present.
REQ-008 earth_dry  in  ZONES  per-zone request, 1 = soil dry.
REQ-009 air_humidity / low_temperature  in  1 each  weather inputs for mode selection.
REQ-010 pulse  in  1  operator acknowledge.
REQ-011 zone_valve  out  ZONES  one-hot zone valve drive.
REQ-012 active_zone  out  ZW  index of the granted zone.
REQ-013 splinker_bomb / dripper_valvule  out  1 each  shared irrigation actuators.
REQ-014 water_supply_valvule  out  1  tank refill valve.
REQ-015 alarm  out  1  fault or low-tank indication.
REQ-016 remaining  out  TW  remaining ticks of the current grant.

Function
REQ-017 All outputs SHALL be registered; the inputs are sampled directly (no synchroniser inside).
REQ-018 conflict SHALL be (high & !mid) | (mid & !low).
REQ-019 The tick prescaler SHALL count 0..TICK_DIV-1 freely and assert tick for one cycle at TICK_DIV-1.
REQ-020 FSM states: IDLE, IRRIGATE, PAUSE, FAULT.
REQ-021 Any state, conflict=1: next state FAULT; the FAULT transition has priority over all others.
REQ-022 IDLE, any earth_dry bit set, low=1: grant the first requesting zone round-robin after last_zone, load remaining=RUN_TICKS, latch mode, enter IRRIGATE.
REQ-023 Latched mode SHALL be splinker when !air_humidity & !low_temperature & mid, else dripper.
REQ-024 IRRIGATE: on tick, decrement remaining; at remaining reaching 0, or earth_dry[active_zone]=0, go to IDLE and set last_zone=active_zone.
REQ-025 Timer expiry and request drop in the same cycle SHALL cause exactly one return to IDLE.
REQ-026 IRRIGATE with low=0: enter PAUSE with remaining held; PAUSE with low=1 returns to IRRIGATE with no reload.
REQ-027 zone_valve[active_zone] and the latched actuator SHALL be 1 only in IRRIGATE; all actuators SHALL be 0 in IDLE, PAUSE and FAULT.
REQ-028 water_supply_valvule SHALL be !high & !conflict; in FAULT it SHALL be 0.
REQ-029 alarm SHALL be 1 in FAULT or when mid=0.
REQ-030 The round-robin SHALL never grant the same zone twice in a row while another zone requests.

Reset
REQ-031 On reset: state IDLE, prescaler 0, remaining 0, last_zone ZONES-1, active_zone 0, all outputs 0.
REQ-032 Reset asserted mid-IRRIGATE SHALL close all valves immediately (asynchronously).

Configuration
REQ-033 Macro IRRIGATION_FAULT_LATCH_EN defined: FAULT exits to IDLE only on pulse=1 with conflict=0.
REQ-034 Macro undefined: FAULT exits to IDLE on the first cycle with conflict=0; pulse is ignored.

Verification
REQ-035 ZONES=4, RUN_TICKS=3, TICK_DIV=2; earth_dry=0101, levels 111 -> zone 0 valve on 6 cycles, then zone 2, then zone 0.
REQ-036 Zone active, drop low at remaining=2 for 10 cycles -> PAUSE, valves 0, remaining stays 2; restore low -> resumes, expires after 2 ticks.
REQ-037 Levels high=1, mid=0 -> FAULT, alarm=1, all valves 0; with macro, stays until pulse; without macro, IDLE 1 cycle after conflict clears.
REQ-038 air_humidity=0, low_temperature=0, mid=1 at grant -> splinker_bomb=1; air_humidity toggled mid-grant -> mode unchanged.
REQ-039 Reset asserted during IRRIGATE -> zone_valve=0 and remaining=0 before the next clock edge.
